sync_frame_deframer: RTL and testbench
======================================

// Module: sync_frame_deframer
// PURPOSE
//  Consumes the serial stream produced by the CRC decode stage (bit_in/valid_in, 80-bit frames:
//  72 payload bits then 8-bit trailing sync word, MSB-first). Hunts for and locks onto the sync
//  word, then packs each frame's 72 payload bits into 9 bytes. Bytes are buffered in a 4-entry
//  FIFO toward the byte-level sink on a valid/ready handshake.
// PARAMETERS
//  SYNC_WORD    8'h47  trailing sync pattern
//  SYNC_LEN     8      sync length in bits (fixed 8; byte packing assumes it)
//  FRAME_LEN    80     total bits per frame incl. sync; payload = FRAME_LEN-SYNC_LEN (multiple of 8)
//  LOCK_COUNT   3      consecutive correctly spaced syncs needed to enter LOCKED (>=1)
//  UNLOCK_COUNT 2      consecutive missed syncs in LOCKED that force HUNT (>=1)
//  FIFO_DEPTH   4      output byte FIFO entries (power of 2)
// PORTS
//  clk         in   1  clock, all state on rising edge
//  rst         in   1  asynchronous active-low reset
//  bit_in      in   1  serial data bit, sampled when valid_in=1
//  valid_in    in   1  bit_in qualifier; no state advances when 0
//  byte_out    out  8  FIFO head byte; first-received payload bit in [7]
//  byte_sof    out  1  head byte is byte 0 of a frame
//  byte_valid  out  1  FIFO non-empty
//  byte_ready  in   1  sink accepts head when byte_valid&byte_ready
//  locked      out  1  FSM in LOCKED
//  frame_err   out  1  1-cycle pulse: sync mismatch while LOCKED
//  overflow    out  1  1-cycle pulse: completed byte dropped, FIFO full
// BEHAVIOUR
//  Reset (rst=0, async): FSM=HUNT, counters/shift reg/FIFO cleared; byte_out=0, byte_sof=0,
//   byte_valid=0, locked=0, frame_err=0, overflow=0. Reset mid-frame discards all partial state.
//  sh[7:0]: shift reg, sh<={sh[6:0],bit_in} on every accepted bit (all states).
//  bit_cnt: 0..FRAME_LEN-1 position within frame, wraps to 0; increments per accepted bit.
//  HUNT: after each accepted bit, if {sh[6:0],bit_in}==SYNC_WORD -> hits=1, bit_cnt=0;
//   then LOCKED if LOCK_COUNT==1 else VERIFY. Overlapping matches allowed. No bytes emitted.
//  VERIFY: at bit_cnt==FRAME_LEN-1 compare {sh[6:0],bit_in} to SYNC_WORD: match -> hits+1,
//   LOCKED when hits+1==LOCK_COUNT; mismatch -> HUNT (re-hunt starts with next bit). No bytes.
//  LOCKED: bit_cnt 0..FRAME_LEN-SYNC_LEN-1 = payload; each 8th bit (bit_cnt[2:0]==7) completes
//   byte {sh[6:0],bit_in}, pushed with sof=(bit_cnt==7). bit_cnt==FRAME_LEN-1: sync compare;
//   match -> miss=0; mismatch -> frame_err pulse, miss+1; miss+1==UNLOCK_COUNT -> HUNT, miss=0.
//   Bytes of a frame with missed sync are not recalled.
//  Latency: byte pushed on edge sampling its 8th bit; byte_valid=1 in cycle after that edge
//   (empty FIFO). Head (byte_out/byte_sof) combinational from FIFO read pointer.
//  FIFO: push and pop same cycle allowed at any fill, incl. full (push accepted, count unchanged).
//   Push when full and no pop -> byte dropped, overflow pulse; FSM/bit_cnt unaffected.
//   byte_out/byte_sof hold stable while byte_valid=1 and byte_ready=0.
//  Widths: bit_cnt $clog2(FRAME_LEN); hits/miss saturate at LOCK_COUNT/UNLOCK_COUNT; FIFO count
//   $clog2(FIFO_DEPTH)+1. valid_in=0 gaps of any length are transparent.
// TESTING
//  T1 reset: rst=0 mid-frame with FIFO holding 2 bytes -> byte_valid=0, locked=0 immediately,
//   HUNT after release.
//  T2 acquire: 3 frames payload 00..08 + sync 8'h47, byte_ready=1 -> locked=1 after 3rd sync bit;
//   4th frame emits 9 bytes 00..08, byte_sof only on 00.
//  T3 false sync: 8'h47 inside payload while HUNT, no 47 80 bits later -> back to HUNT,
//   locked=0, no bytes emitted.
//  T4 loss: locked, corrupt sync to 8'h46 once -> frame_err pulse, locked=1; twice consecutive
//   -> second frame_err, locked=0.
//  T5 backpressure: locked, byte_ready=0 for a full frame -> 4 bytes held (00..03),
//   5 overflow pulses; byte_ready=1 drains 00,01,02,03 in order.
//  T6 gaps: random valid_in=0 stalls between bits of T2 stream -> byte sequence identical to T2.

Source files
------------

// File: rtl/sync_frame_deframer_if.sv
// Byte-stream handshake between the deframer output FIFO head and its downstream sink.
interface sync_frame_deframer_if;
  logic [7:0] byte_out;
  logic       byte_sof;
  logic       byte_valid;
  logic       byte_ready;

  modport master (output byte_out, output byte_sof, output byte_valid, input byte_ready);
  modport slave  (input byte_out, input byte_sof, input byte_valid, output byte_ready);
endinterface

// File: rtl/sync_frame_deframer.sv
// Serial frame deframer: hunts/verifies/locks on a trailing sync word, packs payload bits
// into bytes and buffers them in a small FIFO toward a valid/ready byte sink.
module sync_frame_deframer #(
  parameter logic [7:0] SYNC_WORD    = 8'h47,
  parameter int         SYNC_LEN     = 8,
  parameter int         FRAME_LEN    = 80,
  parameter int         LOCK_COUNT   = 3,
  parameter int         UNLOCK_COUNT = 2,
  parameter int         FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bit_in,
  input  logic                  valid_in,
  sync_frame_deframer_if.master byte_if,
  output logic                  locked,
  output logic                  frame_err,
  output logic                  overflow
);
  localparam int CNT_W  = $clog2(FRAME_LEN);
  localparam int HIT_W  = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W = $clog2(UNLOCK_COUNT + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0]  LAST_BIT    = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0]  PAYLOAD_END = CNT_W'(FRAME_LEN - SYNC_LEN);
  localparam logic [CNT_W-1:0]  SOF_BIT     = CNT_W'(7);
  localparam logic [HIT_W-1:0]  LOCK_MAX    = HIT_W'(LOCK_COUNT);
  localparam logic [MISS_W-1:0] UNLOCK_MAX  = MISS_W'(UNLOCK_COUNT);
  localparam logic [FCNT_W-1:0] FIFO_FULL   = FCNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t            state_r;
  logic [6:0]        sh_r;
  logic [CNT_W-1:0]  bit_cnt_r;
  logic [HIT_W-1:0]  hits_r;
  logic [MISS_W-1:0] miss_r;
  logic              frame_err_r;
  logic              overflow_r;

  logic [8:0]        mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [FCNT_W-1:0] fifo_cnt_r;
  logic [FCNT_W-1:0] fifo_cnt_nxt_s;

  // sh_r keeps the previous 7 bits; with bit_in it forms the 8-bit window ending on this bit
  logic [7:0] sh_next_s;
  logic       sync_hit_s;
  logic       frame_end_s;
  logic       push_s;
  logic       pop_s;
  logic       full_s;
  logic       wr_ok_s;
  logic       drop_s;

  assign sh_next_s   = {sh_r, bit_in};
  assign sync_hit_s  = (sh_next_s == SYNC_WORD);
  assign frame_end_s = (bit_cnt_r == LAST_BIT);
  assign push_s      = valid_in && (state_r == ST_LOCKED) && (bit_cnt_r < PAYLOAD_END)
                       && (bit_cnt_r[2:0] == 3'd7);
  assign pop_s       = (fifo_cnt_r != '0) && byte_if.byte_ready;
  assign full_s      = (fifo_cnt_r == FIFO_FULL);
  assign wr_ok_s     = push_s && (!full_s || pop_s);
  assign drop_s      = push_s && full_s && !pop_s;

  assign byte_if.byte_out   = mem_r[rd_ptr_r][7:0];
  assign byte_if.byte_sof   = mem_r[rd_ptr_r][8];
  assign byte_if.byte_valid = (fifo_cnt_r != '0);
  assign locked             = (state_r == ST_LOCKED);
  assign frame_err          = frame_err_r;
  assign overflow           = overflow_r;

  // Frame alignment FSM: window shift, bit position, hit/miss counters and error pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_HUNT;
      sh_r        <= 7'd0;
      bit_cnt_r   <= '0;
      hits_r      <= '0;
      miss_r      <= '0;
      frame_err_r <= 1'b0;
    end else begin
      frame_err_r <= 1'b0;
      if (valid_in) begin
        sh_r      <= sh_next_s[6:0];
        bit_cnt_r <= frame_end_s ? '0 : bit_cnt_r + CNT_W'(1);
        case (state_r)
          ST_HUNT: begin
            if (sync_hit_s) begin
              hits_r    <= HIT_W'(1);
              miss_r    <= '0;
              bit_cnt_r <= '0;
              state_r   <= (LOCK_COUNT == 1) ? ST_LOCKED : ST_VERIFY;
            end
          end
          ST_VERIFY: begin
            if (frame_end_s) begin
              if (!sync_hit_s) begin
                state_r <= ST_HUNT;
              end else if (hits_r + HIT_W'(1) == LOCK_MAX) begin
                hits_r  <= LOCK_MAX;
                miss_r  <= '0;
                state_r <= ST_LOCKED;
              end else begin
                hits_r <= hits_r + HIT_W'(1);
              end
            end
          end
          ST_LOCKED: begin
            if (frame_end_s) begin
              if (sync_hit_s) begin
                miss_r <= '0;
              end else begin
                frame_err_r <= 1'b1;
                if (miss_r + MISS_W'(1) == UNLOCK_MAX) begin
                  miss_r  <= '0;
                  state_r <= ST_HUNT;
                end else begin
                  miss_r <= miss_r + MISS_W'(1);
                end
              end
            end
          end
          default: state_r <= ST_HUNT;
        endcase
      end
    end
  end

  // Occupancy update: a write and a read in the same cycle leave the count unchanged
  always_comb begin
    fifo_cnt_nxt_s = fifo_cnt_r;
    case ({wr_ok_s, pop_s})
      2'b10:   fifo_cnt_nxt_s = fifo_cnt_r + FCNT_W'(1);
      2'b01:   fifo_cnt_nxt_s = fifo_cnt_r - FCNT_W'(1);
      default: fifo_cnt_nxt_s = fifo_cnt_r;
    endcase
  end

  // Output byte FIFO storage, pointers and overflow pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 9'd0;
      end
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      fifo_cnt_r <= '0;
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= drop_s;
      if (wr_ok_s) begin
        mem_r[wr_ptr_r] <= {(bit_cnt_r == SOF_BIT), sh_next_s};
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      fifo_cnt_r <= fifo_cnt_nxt_s;
    end
  end
endmodule

// File: tb/tb_sync_frame_deframer.sv
// Scoreboard bench for sync_frame_deframer: acquisition, false sync, loss of lock,
// backpressure/overflow, mid-frame reset and valid_in gaps.
module tb_sync_frame_deframer;
  logic clk      = 1'b0;
  logic rst      = 1'b0;
  logic bit_in   = 1'b0;
  logic valid_in = 1'b0;
  logic locked;
  logic frame_err;
  logic overflow;

  sync_frame_deframer_if bif ();

  sync_frame_deframer dut (
    .clk      (clk),
    .rst      (rst),
    .bit_in   (bit_in),
    .valid_in (valid_in),
    .byte_if  (bif.master),
    .locked   (locked),
    .frame_err(frame_err),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         err_cnt  = 0;
  int         ovf_cnt  = 0;
  int         exp_err  = 0;
  int         exp_ovf  = 0;
  bit         gaps     = 1'b0;
  logic [8:0] exp_q[$];
  logic [8:0] mon_exp;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Sink side: count status pulses and score every accepted byte against the queue
  always @(negedge clk) begin
    if (rst) begin
      if (frame_err) err_cnt++;
      if (overflow)  ovf_cnt++;
      if (bif.byte_valid && bif.byte_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("extra_byte", 32'(bif.byte_out), 32'h100);
        end else begin
          mon_exp = exp_q.pop_front();
          check_eq("byte_out", 32'(bif.byte_out), 32'(mon_exp[7:0]));
          check_eq("byte_sof", 32'(bif.byte_sof), 32'(mon_exp[8]));
        end
      end
    end
  end

  task automatic send_bit(input logic b);
    bit_in   = b;
    valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    bit_in   = 1'($urandom_range(0, 1));
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  // n_keep: how many of the 9 payload bytes the sink should eventually see
  task automatic send_frame(input logic [7:0] base, input logic [7:0] sync, input int n_keep);
    logic [7:0] v;
    for (int i = 0; i < 9; i++) begin
      v = base + 8'(i);
      if (i < n_keep) exp_q.push_back({(i == 0), v});
      send_byte(v);
    end
    send_byte(sync);
  endtask

  task automatic acquire(input string tag);
    send_frame(8'h00, 8'h47, 0);
    check_eq({tag, "_lock1"}, 32'(locked), 32'd0);
    send_frame(8'h00, 8'h47, 0);
    check_eq({tag, "_lock2"}, 32'(locked), 32'd0);
    send_frame(8'h00, 8'h47, 0);
    check_eq({tag, "_lock3"}, 32'(locked), 32'd1);
  endtask

  task automatic wait_drain(input string tag);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check_eq(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #3;
    rst = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_ovf;
    bif.byte_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", 32'(bif.byte_valid), 32'd0);
    check_eq("rst_locked", 32'(locked), 32'd0);
    check_eq("rst_ferr", 32'(frame_err), 32'd0);
    check_eq("rst_ovf", 32'(overflow), 32'd0);
    check_eq("rst_byte", 32'(bif.byte_out), 32'd0);
    check_eq("rst_sof", 32'(bif.byte_sof), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // acquire then one locked frame
    acquire("t2");
    send_frame(8'h00, 8'h47, 9);
    wait_drain("t2_drain");

    // loss of lock: single miss recovers, two consecutive misses unlock
    send_frame(8'h10, 8'h46, 9);
    check_eq("t4_err1", 32'(frame_err), 32'd1);
    check_eq("t4_lock1", 32'(locked), 32'd1);
    @(posedge clk); #1;
    check_eq("t4_err1_end", 32'(frame_err), 32'd0);
    send_frame(8'h20, 8'h47, 9);
    check_eq("t4_err_ok", 32'(frame_err), 32'd0);
    send_frame(8'h30, 8'h46, 9);
    check_eq("t4_err2", 32'(frame_err), 32'd1);
    check_eq("t4_lock2", 32'(locked), 32'd1);
    send_frame(8'h40, 8'h46, 9);
    check_eq("t4_err3", 32'(frame_err), 32'd1);
    check_eq("t4_lock3", 32'(locked), 32'd0);
    exp_err += 3;
    wait_drain("t4_drain");

    // backpressure for a whole frame
    acquire("t5");
    bif.byte_ready = 1'b0;
    base_ovf = ovf_cnt;
    send_frame(8'h00, 8'h47, 4);
    exp_ovf += 5;
    check_eq("t5_ovf", 32'(ovf_cnt - base_ovf), 32'd5);
    check_eq("t5_valid", 32'(bif.byte_valid), 32'd1);
    check_eq("t5_head", 32'(bif.byte_out), 32'h00);
    check_eq("t5_head_sof", 32'(bif.byte_sof), 32'd1);
    check_eq("t5_lock", 32'(locked), 32'd1);
    bif.byte_ready = 1'b1;
    wait_drain("t5_drain");

    // reset mid-frame with two bytes buffered
    bif.byte_ready = 1'b0;
    exp_q.push_back({1'b1, 8'h00});
    exp_q.push_back({1'b0, 8'h01});
    send_byte(8'h00);
    send_byte(8'h01);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    check_eq("t1_pre_valid", 32'(bif.byte_valid), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_eq("t1_valid", 32'(bif.byte_valid), 32'd0);
    check_eq("t1_locked", 32'(locked), 32'd0);
    check_eq("t1_byte", 32'(bif.byte_out), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    bif.byte_ready = 1'b1;

    // false sync inside hunt, nothing matching one frame later
    send_byte(8'h47);
    for (int i = 0; i < 10; i++) send_byte(8'h00);
    check_eq("t3_locked", 32'(locked), 32'd0);
    check_eq("t3_valid", 32'(bif.byte_valid), 32'd0);
    acquire("t3");
    send_frame(8'h00, 8'h47, 9);
    wait_drain("t3_drain");

    // same stream with random valid_in gaps
    pulse_reset();
    gaps = 1'b1;
    acquire("t6");
    send_frame(8'h00, 8'h47, 9);
    gaps = 1'b0;
    wait_drain("t6_drain");

    repeat (4) @(posedge clk);
    #1;
    check_eq("total_frame_err", 32'(err_cnt), 32'(exp_err));
    check_eq("total_overflow", 32'(ovf_cnt), 32'(exp_ovf));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
